// File: rtl/div_if.sv
// Request/response bundle between the execute-stage controller and the
// iterative divide unit.
interface div_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, rs1, rs2,
    input  busy, done, result
  );

  modport slave (
    input  start, op, rs1, rs2,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: restoring division on magnitudes,
// one quotient bit per cycle, sign fix-up applied when the last bit lands.
module div_unit #(
  parameter int XLEN = 32
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] q, q_nx;
  logic [XLEN-1:0] d, d_nx;
  logic [XLEN:0]   r, r_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [1:0]      op_q, op_nx;
  logic            neg_a, neg_a_nx;
  logic            neg_b, neg_b_nx;
  logic [XLEN-1:0] result, result_nx;

  logic [XLEN:0]   shifted, trial, r_step;
  logic [XLEN-1:0] q_step, quot_fix, rem_fix;
  logic            sgn_op, a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0] abs_a, abs_b;

  // One restoring step plus the sign-corrected views of its outcome.
  always_comb begin
    shifted = (r << 1) | {{XLEN{1'b0}}, q[XLEN-1]};
    trial   = shifted - {1'b0, d};
    if (!trial[XLEN]) begin
      r_step = trial;
      q_step = {q[XLEN-2:0], 1'b1};
    end else begin
      r_step = shifted;
      q_step = {q[XLEN-2:0], 1'b0};
    end
    quot_fix = (neg_a ^ neg_b) ? -q_step : q_step;
    rem_fix  = neg_a ? -r_step[XLEN-1:0] : r_step[XLEN-1:0];
  end

  // Operand decode at acceptance; op[0] marks the unsigned variants.
  always_comb begin
    sgn_op   = ~bus.op[0];
    a_neg    = sgn_op & bus.rs1[XLEN-1];
    b_neg    = sgn_op & bus.rs2[XLEN-1];
    abs_a    = a_neg ? -bus.rs1 : bus.rs1;
    abs_b    = b_neg ? -bus.rs2 : bus.rs2;
    div_zero = (bus.rs2 == '0);
    overflow = sgn_op && (bus.rs1 == MIN_NEG) && (bus.rs2 == '1);
  end

  always_comb begin
    state_nx  = state;
    q_nx      = q;
    d_nx      = d;
    r_nx      = r;
    cnt_nx    = cnt;
    op_nx     = op_q;
    neg_a_nx  = neg_a;
    neg_b_nx  = neg_b;
    result_nx = result;
    case (state)
      IDLE: begin
        if (bus.start) begin
          op_nx    = bus.op;
          neg_a_nx = a_neg;
          neg_b_nx = b_neg;
          q_nx     = abs_a;
          d_nx     = abs_b;
          r_nx     = '0;
          cnt_nx   = CW'(XLEN - 1);
          // Architecturally defined corner cases skip the iteration entirely.
          if (div_zero) begin
            result_nx = bus.op[1] ? bus.rs1 : '1;
            state_nx  = DONE;
          end else if (overflow) begin
            result_nx = bus.op[1] ? '0 : MIN_NEG;
            state_nx  = DONE;
          end else begin
            state_nx = CALC;
          end
        end
      end
      CALC: begin
        q_nx   = q_step;
        r_nx   = r_step;
        cnt_nx = cnt - CW'(1);
        if (cnt == '0) begin
          result_nx = op_q[1] ? rem_fix : quot_fix;
          state_nx  = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q      <= '0;
      d      <= '0;
      r      <= '0;
      cnt    <= '0;
      op_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nx;
      q      <= q_nx;
      d      <= d_nx;
      r      <= r_nx;
      cnt    <= cnt_nx;
      op_q   <= op_nx;
      neg_a  <= neg_a_nx;
      neg_b  <= neg_b_nx;
      result <= result_nx;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a vector table of signed/unsigned and corner
// divisions, plus sequences for ignored starts and mid-operation reset.
module tb_div_unit;

  localparam int XLEN = 32;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_if #(.XLEN(XLEN)) bus ();

  div_unit #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input string name, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input int expLat);
    vec_t v;
    v.name   = name;
    v.op     = op;
    v.a      = a;
    v.b      = b;
    v.expRes = expRes;
    v.expLat = expLat;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  // Called one tick after a rising edge with the unit idle; returns on the done cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, output logic [31:0] res,
                               output int lat, output int busyCycles);
    bus.op     = op;
    bus.rs1    = a;
    bus.rs2    = b;
    bus.start  = 1'b1;
    lat        = 0;
    busyCycles = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.busy) busyCycles++;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    res = bus.result;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] res;
    int          lat;
    int          busyCycles;
    logic        sawDone;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.rs1   = '0;
    bus.rs2   = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy",   32'(bus.busy),   32'd0);
    checkOutput("reset done",   32'(bus.done),   32'd0);
    checkOutput("reset result", bus.result,      32'd0);
    rst = 1'b0;

    addVec("DIVU 100/7",        OP_DIVU, 32'd100,        32'd7,          32'd14,         33);
    addVec("REMU 100/7",        OP_REMU, 32'd100,        32'd7,          32'd2,          33);
    addVec("DIV -7/2",          OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
    addVec("REM -7/2",          OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
    addVec("REM 7/-2",          OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33);
    addVec("DIV 100/-7",        OP_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  33);
    addVec("DIV -100/-7",       OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33);
    addVec("REM -100/-7",       OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  33);
    addVec("DIVU max/1",        OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33);
    addVec("REMU max/16",       OP_REMU, 32'hFFFF_FFFF,  32'd16,         32'd15,         33);
    addVec("DIVU 5/0",          OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
    addVec("REM 5/0",           OP_REM,  32'd5,          32'd0,          32'd5,          1);
    addVec("DIV -5/0",          OP_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1);
    addVec("REMU 100/0",        OP_REMU, 32'd100,        32'd0,          32'd100,        1);
    addVec("DIV overflow",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
    addVec("REM overflow",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);
    addVec("DIVU min/max",      OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33);
    addVec("REMU min/max",      OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busyCycles);
      checkOutput({vecs[i].name, " result"},  res,                vecs[i].expRes);
      checkOutput({vecs[i].name, " latency"}, 32'(lat),           32'(vecs[i].expLat));
      checkOutput({vecs[i].name, " busy"},    32'(busyCycles),    32'(vecs[i].expLat));
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, " idle after"}, {30'd0, bus.busy, bus.done}, 32'd0);
    end

    // Starts during CALC and during the DONE cycle must not disturb the op.
    bus.op    = OP_DIVU;
    bus.rs1   = 32'd100;
    bus.rs2   = 32'd7;
    bus.start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 33) begin
        checkOutput("ignored-start done",   32'(bus.done), 32'd1);
        checkOutput("ignored-start result", bus.result,    32'd14);
      end
      if (n == 34) checkOutput("start in DONE ignored", 32'(bus.busy), 32'd0);
      if (n == 5) begin
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.rs1   = 32'd1000;
        bus.rs2   = 32'd3;
      end else if (n == 33) begin
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.rs1   = 32'd77;
        bus.rs2   = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
    end
    checkOutput("ignored-start held result", bus.result, 32'd14);
    checkOutput("ignored-start idle", {30'd0, bus.busy, bus.done}, 32'd0);

    // Reset in the middle of CALC aborts without a done pulse.
    bus.op    = OP_DIVU;
    bus.rs1   = 32'd100;
    bus.rs2   = 32'd7;
    bus.start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    checkOutput("pre-reset busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mid-reset busy",   32'(bus.busy), 32'd0);
    checkOutput("mid-reset done",   32'(bus.done), 32'd0);
    checkOutput("mid-reset result", bus.result,    32'd0);
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) sawDone = 1'b1;
    end
    checkOutput("no done after reset", 32'(sawDone), 32'd0);

    applyStimulus(OP_DIVU, 32'd9, 32'd3, res, lat, busyCycles);
    checkOutput("post-reset DIVU 9/3 result",  res,      32'd3);
    checkOutput("post-reset DIVU 9/3 latency", 32'(lat), 32'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divide unit that executes DIV, DIVU, REM and REMU for the execute stage. It sits alongside the ALU adder path and uses a single XLEN+1-bit subtractor for restoring division, producing one quotient bit per cycle. The execute-stage controller holds the pipeline while `busy` is high. It captures `result` on the one-cycle `done` pulse.

## Interface
- `XLEN`, default 32: operand and result width.

- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: request. Sampled only in IDLE.
- `op` input 2: operation select. 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `rs1` input XLEN: dividend. Sampled with `start`.
- `rs2` input XLEN: divisor. Sampled with `start`.
- `busy` output 1: high whenever state is not IDLE.
- `done` output 1: one-cycle pulse. `result` is valid in this cycle.
- `result` output XLEN: quotient or remainder. Held until the next accepted `start`.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE + `start`:**
  - Latch `op` and the sign flags. Signed ops (DIV, REM) use each operand's MSB; unsigned ops use 0.
  - Load `|rs1|` into the quotient shift register Q and `|rs2|` into the divisor register D.
  - Clear the partial remainder R (XLEN+1 bits) and set the iteration counter to XLEN-1.
- **Special cases** are detected at `start`; no iteration is performed:
  - Divisor = 0: quotient = all ones, remainder = `rs1`. Go directly to DONE.
  - Signed overflow (DIV/REM, `rs1` = 0x80000000, `rs2` = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. Go directly to DONE.
  - The special-case result is written to `result` on the same edge as the transition.
- **CALC**, one iteration per cycle:
  - T = {R[XLEN-1:0], Q[XLEN-1]} − {1'b0, D}, computed at XLEN+1 bits.
  - If T[XLEN] = 0: R ← T and Q ← {Q[XLEN-2:0], 1}.
  - Otherwise: R ← {R[XLEN-1:0], Q[XLEN-1]} and Q ← {Q[XLEN-2:0], 0}.
  - The counter decrements each cycle. On the iteration where the counter is 0, go to DONE.
- **Sign fix-up** is applied on the CALC→DONE edge, and the value is written to `result`:
  - Quotient is negated (two's complement) if the dividend sign differs from the divisor sign.
  - Remainder is negated if the dividend is negative.
  - DIV/DIVU write the quotient; REM/REMU write the remainder.
- **DONE:** `done` = 1 for exactly one cycle, then the unit returns to IDLE unconditionally.
- **`start` while `busy`:** ignored; no operands are latched. A `start` that arrives in the DONE cycle is also ignored.
- **Reset:**
  - All outputs reset to 0: `busy`, `done` and `result`. State goes to IDLE.
  - Reset mid-CALC or in DONE aborts the operation with no `done` pulse.

## Timing
- Start accepted at edge E0.
- Normal operation: CALC occupies the cycles after E0 through E(XLEN). `done` is high in the cycle after edge E(XLEN), i.e. XLEN+1 cycles after acceptance (33 for XLEN = 32).
- Special cases: `done` is high in the cycle immediately after E0, a latency of 1.
- `busy` rises in the cycle after E0 and falls in the cycle after the `done` cycle.
- Back-to-back operations: earliest next `start` acceptance is at the first IDLE cycle. Throughput is one op per XLEN+2 cycles, or one per 2 cycles for special cases.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- **DIVU 100/7:** `result` = 14, `done` exactly 33 cycles after `start`. **REMU 100/7:** `result` = 2. `busy` is high for 33 cycles.
- **DIV −7/2** (0xFFFFFFF9, 2): `result` = 0xFFFFFFFD (−3). **REM −7/2:** `result` = 0xFFFFFFFF (−1). **REM 7/−2:** `result` = 1.
- **Divide by zero:**
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV −5/0 → 0xFFFFFFFF.
  - In every case `done` arrives 1 cycle after `start`.
- **Overflow:** DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. Latency is 1. Also DIVU 0x80000000/0xFFFFFFFF → 0 (normal path, 33 cycles).
- **`start` with new operands at cycles 5 and 33 of a busy op:** both are ignored, and `result` reflects the original operands only.
- **`rst` asserted at cycle 10 of CALC:** next cycle `busy` = 0, `done` = 0 and `result` = 0. No `done` pulse appears later. A following DIVU 9/3 returns 3 normally.
